apb_requester: RTL
==================

Name: apb_requester

Overview:
- Initiator end of the APB bus: turns single CPU load/store requests (valid/ready) into APB SETUP/ACCESS transfers on psel/penable/paddr/pdata/pwrite/pstb.
- Waits for pready, captures prdata/perr and returns a one-cycle response to the core.
- Sits between the CPU memory stage and the bus address decoder (which fans out to SRAM, UART and system registers); drives the decoder's inputs and consumes its pready/prdata/perr.

Parameters:
- ADDR_WIDTH, 32, width of req_addr/paddr
- DATA_WIDTH, 32, width of write/read data
- TIMEOUT_CYCLES, 256, max ACCESS-phase cycles before abort (used only with the optional feature; must be ≥2)

Ports:
- pclk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous active-high reset
- req_valid  input  1  CPU request present
- req_ready  output  1  requester idle; request accepted when req_valid && req_ready
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data
- req_write  input  1  1=store, 0=load
- req_strb  input  4  byte strobes for stores
- resp_valid  output  1  one-cycle pulse: transfer complete
- resp_rdata  output  DATA_WIDTH  load data, valid with resp_valid
- resp_err  output  1  transfer faulted, valid with resp_valid
- paddr  output  ADDR_WIDTH  APB address
- pdata  output  DATA_WIDTH  APB write data
- pwrite  output  1  APB direction
- pstb  output  4  APB write strobes
- psel  output  1  APB select
- penable  output  1  APB enable
- prdata  input  DATA_WIDTH  APB read data
- pready  input  1  APB ready
- perr  input  1  APB error

Behaviour:
- All outputs registered. Reset, applied in any state, forces the next-edge values: state IDLE, psel=0, penable=0, paddr=0, pdata=0, pwrite=0, pstb=0, resp_valid=0, resp_rdata=0, resp_err=0, timeout counter 0. req_ready=1 after reset.
- Reset mid-transfer abandons the transfer; no resp_valid is produced for it.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr/wdata/write into paddr/pdata/pwrite. pstb=req_strb for stores, pstb=0 for loads. Go to SETUP.
- SETUP:
  - psel=1, penable=0, req_ready=0. Unconditionally go to ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - paddr/pdata/pwrite/pstb held stable from SETUP until completion.
  - On pready=1: resp_valid=1 next cycle. resp_err=perr. resp_rdata=prdata for loads, 0 for stores. psel and penable drop to 0. Go to IDLE.
  - perr and prdata are ignored unless pready=1.
- Latency: request accepted at edge T → SETUP visible T+1 → ACCESS T+2. With pready at T+2, resp_valid is high during T+3 and req_ready is high at T+3.
- Throughput: one transfer per 3 cycles at best. A new request is accepted in the same cycle resp_valid is high.
- resp_valid is a single-cycle pulse. resp_rdata and resp_err hold their last values until the next response.
- psel never deasserts without a completion, except on reset or timeout.
- A faulted load (perr=1) still returns the captured prdata. The consumer ignores data when resp_err=1.

Optional Feature:
- Macro: APB_REQUESTER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES-1 with pready still 0, the transfer is aborted: psel and penable drop, resp_valid=1, resp_err=1, resp_rdata=0, go to IDLE.
  - pready=1 on the same cycle as expiry wins; the transfer completes normally.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter. ACCESS waits indefinitely for pready.

Test Plan:
- Load, zero wait: req 0x80000010 read, pready=1 first ACCESS cycle, prdata=0xDEADBEEF → psel 2 cycles, penable 1 cycle, resp_valid at T+3, resp_rdata=0xDEADBEEF, resp_err=0, pstb=0.
- Store, 3 wait states: req 0x10000000 write 0x00000041 strb 0x1, pready low 3 ACCESS cycles → paddr/pdata/pstb stable 5 cycles, resp_valid once, resp_rdata=0, resp_err=0.
- Error: read 0x20000000, pready=1 with perr=1 → resp_err=1, resp_valid one cycle, req_ready high the same cycle.
- Back-to-back: req_valid held high with 3 requests → accepted at T, T+3, T+6; exactly 3 resp_valid pulses, in order, with correct data.
- Reset mid-ACCESS: assert reset while pready=0 → psel=penable=0 next edge, no resp_valid, req_ready=1.
- With APB_REQUESTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready never high → abort after 4 ACCESS cycles, resp_err=1, resp_rdata=0. Repeat with pready on the 4th cycle → normal completion, resp_err=perr.

Source files
------------

// File: rtl/apb_requester_if.sv
// -----------------------------------------------------------------------------
// apb_requester_if
//
// Bundles the CPU request/response handshake and the APB initiator bus that
// the apb_requester bridges between.
//
// Signal summary:
//   req_valid / req_ready        CPU request handshake
//   req_addr / req_wdata         request byte address and store data
//   req_write / req_strb         1 = store, 0 = load; store byte strobes
//   resp_valid                   one-cycle completion pulse
//   resp_rdata / resp_err        load data and fault flag, valid with resp_valid
//   paddr / pdata / pwrite       APB address, write data, direction
//   pstb                         APB write strobes
//   psel / penable               APB phase controls
//   prdata / pready / perr       APB completer return path
//
// Modports:
//   master : the requester side (drives req_ready, resp_* and p* controls)
//   slave  : the environment side (CPU core plus APB completer)
// -----------------------------------------------------------------------------
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_write;
    logic [3:0]            req_strb;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pdata;
    logic                  pwrite;
    logic [3:0]            pstb;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  perr;

    modport master (
        input  req_valid, req_addr, req_wdata, req_write, req_strb,
        input  prdata, pready, perr,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output paddr, pdata, pwrite, pstb, psel, penable
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_write, req_strb,
        output prdata, pready, perr,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  paddr, pdata, pwrite, pstb, psel, penable
    );
endinterface

// File: rtl/apb_requester.sv
// -----------------------------------------------------------------------------
// apb_requester
//
// APB initiator: converts single CPU load/store requests into APB SETUP/ACCESS
// transfers, waits for pready, and returns a one-cycle response (resp_valid)
// carrying the captured read data and error flag. Every output is registered.
//
// Ports:
//   pclk   - clock, all logic on the rising edge
//   reset  - synchronous active-high reset
//   bus    - apb_requester_if.master: CPU request/response handshake and the
//            APB bus (paddr/pdata/pwrite/pstb/psel/penable, prdata/pready/perr)
//
// Optional feature (macro APB_REQUESTER_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees pready low for TIMEOUT_CYCLES
//   cycles is aborted and answered with resp_err=1, resp_rdata=0. When not
//   defined, ACCESS waits for pready indefinitely.
// -----------------------------------------------------------------------------
module apb_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   pclk,
    input  logic                   reset,
    apb_requester_if.master        bus
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("apb_requester: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  pwrite_q, pwrite_d;
    logic [3:0]            pstb_q, pstb_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

`ifdef APB_REQUESTER_TIMEOUT_EN
    localparam int                 CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]              cnt_q, cnt_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        paddr_d      = paddr_q;
        pdata_d      = pdata_q;
        pwrite_d     = pwrite_q;
        pstb_d       = pstb_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
`ifdef APB_REQUESTER_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                // req_ready is always high in IDLE, so req_valid alone accepts.
                if (bus.req_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = bus.req_addr;
                    pdata_d   = bus.req_wdata;
                    pwrite_d  = bus.req_write;
                    pstb_d    = bus.req_write ? bus.req_strb : 4'b0000;
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_REQUESTER_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end

            ACCESS: begin
                // prdata/perr are only meaningful alongside pready.
                if (bus.pready) begin
                    state_d      = IDLE;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = bus.perr;
                    resp_rdata_d = pwrite_q ? '0 : bus.prdata;
                end
`ifdef APB_REQUESTER_TIMEOUT_EN
                // pready on the expiry cycle is handled above and wins.
                else if (cnt_q == CNT_MAX) begin
                    state_d      = IDLE;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // Registered ready: high exactly when the next cycle is spent in IDLE,
        // which lets a new request in during the resp_valid cycle.
        req_ready_d = (state_d == IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pdata_q      <= '0;
            pwrite_q     <= 1'b0;
            pstb_q       <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef APB_REQUESTER_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pdata_q      <= pdata_d;
            pwrite_q     <= pwrite_d;
            pstb_q       <= pstb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef APB_REQUESTER_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.paddr      = paddr_q;
    assign bus.pdata      = pdata_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.pstb       = pstb_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule
